// File: rtl/harris_pkg.sv
// Shared types and sizing helpers for the Harris window producer and score pipeline.
package harris_pkg;

  localparam int WIN_SIZE = 6;
  localparam int PIX_W    = 8;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [0:WIN_SIZE-1][0:WIN_SIZE-1] win_t;

  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/harris_line_buffer.sv
// One line of pixel storage: single write port, async read at the same address.
module harris_line_buffer
  import harris_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int PIX_W = 8,
  localparam int AW = coord_w(IMG_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [IMG_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // read returns the value from before this edge's write
  assign rdata = mem[addr];

endmodule

// File: rtl/harris_window_gen.sv
// Raster pixel stream to 6x6 sliding window with in-frame strobe.
module harris_window_gen
  import harris_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8,
  parameter int WIN   = 6,
  localparam int XW = coord_w(IMG_W),
  localparam int YW = coord_w(IMG_H)
) (
  input  logic clk,
  input  logic reset,
  input  logic pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic sof,
  output logic [0:WIN-1][0:WIN-1][PIX_W-1:0] window,
  output logic win_valid,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y,
  output logic frame_done
);

  if (WIN != 6 || PIX_W != 8) begin : g_cfg_err
    $error("harris_window_gen: WIN must be 6 and PIX_W must be 8");
  end

  logic [XW-1:0] col, cur_col;
  logic [YW-1:0] row, cur_row;
  logic last_col, last_row, in_frame;

  logic [PIX_W-1:0] lb_rd [WIN-1];
  logic [PIX_W-1:0] lb_wd [WIN-1];
  logic [0:WIN-1][PIX_W-1:0] col_vec;

  assign cur_col  = sof ? '0 : col;
  assign cur_row  = sof ? '0 : row;
  assign last_col = cur_col == XW'(IMG_W - 1);
  assign last_row = cur_row == YW'(IMG_H - 1);
  assign in_frame = (cur_col >= XW'(WIN - 1))
                 && (cur_row >= YW'(WIN - 1));

  for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
    if (k == 0) begin : g_first
      assign lb_wd[k] = pix_data;
    end else begin : g_next
      assign lb_wd[k] = lb_rd[k-1];
    end
    harris_line_buffer #(
      .IMG_W(IMG_W),
      .PIX_W(PIX_W)
    ) u_lb (
      .clk  (clk),
      .we   (pix_valid && reset),
      .addr (cur_col),
      .wdata(lb_wd[k]),
      .rdata(lb_rd[k])
    );
  end

  // oldest line lands in window row 0, live pixel in the bottom row
  always_comb begin
    col_vec = '0;
    col_vec[WIN-1] = pix_data;
    for (int r = 0; r < WIN - 1; r++) begin
      col_vec[r] = lb_rd[WIN-2-r];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      window     <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        for (int r = 0; r < WIN; r++) begin
          window[r] <= {window[r][1:WIN-1], col_vec[r]};
        end
        if (in_frame) begin
          win_valid <= 1'b1;
          win_x     <= cur_col - XW'(WIN - 1);
          win_y     <= cur_row - YW'(WIN - 1);
        end
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row        <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= cur_row + 1'b1;
          end
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_harris_window_gen.sv
// Scoreboard bench for harris_window_gen on an 8x8 frame.
module tb_harris_window_gen;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int XW = 3;
  localparam int YW = 3;

  typedef logic [0:5][0:5][7:0] win_vec_t;
  typedef struct {
    win_vec_t w;
    int x;
    int y;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic pix_valid;
  logic [7:0] pix_data;
  logic sof;
  win_vec_t window;
  logic win_valid;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic frame_done;

  harris_window_gen #(
    .IMG_W(W),
    .IMG_H(H),
    .PIX_W(8),
    .WIN(6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .sof       (sof),
    .window    (window),
    .win_valid (win_valid),
    .win_x     (win_x),
    .win_y     (win_y),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  exp_t q[$];
  logic [7:0] img [H][W];
  int mrow = 0, mcol = 0;
  int acc_cnt = 0, frame_base = 0;
  int first_win_at = -1, fd_at = -1;
  int n_win = 0, n_fd = 0;
  bit last_acc = 0;
  bit rnd_val = 0;

  task automatic chk(string nm, bit ok,
                     logic [287:0] act, logic [287:0] exp_v);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
  endtask

  task automatic drive(bit v, logic [7:0] p, bit s);
    exp_t e;
    pix_valid = v;
    pix_data  = p;
    sof       = s;
    if (v) begin
      if (s) begin
        mrow = 0;
        mcol = 0;
      end
      img[mrow][mcol] = p;
      if (mcol >= 5 && mrow >= 5) begin
        e.x = mcol - 5;
        e.y = mrow - 5;
        for (int r = 0; r < 6; r++)
          for (int c = 0; c < 6; c++)
            e.w[r][c] = img[e.y+r][e.x+c];
        q.push_back(e);
      end
      if (mcol == W - 1) begin
        mcol = 0;
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
    @(posedge clk);
    #1;
    last_acc = v;
    if (v) acc_cnt++;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic send_px(int r, int c, bit s, bit gaps);
    logic [7:0] p;
    if (gaps) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(1) == 0) break;
        drive(1'b0, 8'($urandom), 1'($urandom_range(1)));
      end
    end
    p = rnd_val ? 8'($urandom) : 8'(r * 16 + c);
    drive(1'b1, p, s);
  endtask

  task automatic send_frame(bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_px(r, c, (r == 0 && c == 0), gaps);
  endtask

  task automatic start_test();
    frame_base   = acc_cnt;
    first_win_at = -1;
    fd_at        = -1;
    n_win        = 0;
    n_fd         = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_window"}, window == '0, window, 0);
    chk({nm, "_valid"}, win_valid == 1'b0, win_valid, 0);
    chk({nm, "_xy"}, {win_x, win_y} == '0, {win_x, win_y}, 0);
    chk({nm, "_fdone"}, frame_done == 1'b0, frame_done, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (win_valid) begin
      n_win++;
      if (first_win_at < 0) first_win_at = acc_cnt - frame_base;
      chk("win_after_accept", last_acc, last_acc, 1);
      chk("win_queued", q.size() > 0, q.size(), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("win_data", window == e.w, window, e.w);
        chk("win_x", int'(win_x) == e.x, win_x, e.x);
        chk("win_y", int'(win_y) == e.y, win_y, e.y);
      end
    end
    if (frame_done) begin
      n_fd++;
      fd_at = acc_cnt - frame_base;
    end
  end

  initial begin
    win_vec_t wexp;
    reset     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    sof       = 1'b0;
    @(posedge clk);
    #1;
    pix_valid = 1'b1;
    pix_data  = 8'h5a;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    chk_zero("reset");
    reset = 1'b1;
    idle(2);

    // 1: continuous frame
    start_test();
    send_frame(1'b0);
    idle(3);
    chk("t1_first_win", first_win_at == 46, first_win_at, 46);
    chk("t1_nwin", n_win == 9, n_win, 9);
    chk("t1_nfd", n_fd == 1, n_fd, 1);
    chk("t1_fd_at", fd_at == 64, fd_at, 64);

    // 2: random gaps and stray sof on idle cycles
    start_test();
    send_frame(1'b1);
    idle(3);
    chk("t2_nwin", n_win == 9, n_win, 9);
    chk("t2_nfd", n_fd == 1, n_fd, 1);

    // 3: line wrap at row 6
    start_test();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < W; c++)
        send_px(r, c, (r == 0 && c == 0), 1'b0);
    for (int c = 0; c < 5; c++) begin
      send_px(6, c, 1'b0, 1'b0);
      chk("t3_wrap_quiet", win_valid == 1'b0, win_valid, 0);
    end
    send_px(6, 5, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        wexp[r][c] = 8'((r + 1) * 16 + c);
    chk("t3_valid", win_valid == 1'b1, win_valid, 1);
    chk("t3_window", window == wexp, window, wexp);
    chk("t3_xy", win_x == 3'd0 && win_y == 3'd1, {win_x, win_y}, 1);
    for (int c = 6; c < W; c++) send_px(6, c, 1'b0, 1'b0);
    for (int c = 0; c < W; c++) send_px(7, c, 1'b0, 1'b0);
    idle(3);
    chk("t3_nwin", n_win == 9, n_win, 9);
    chk("t3_nfd", n_fd == 1, n_fd, 1);

    // 4: sof mid-frame at row 3
    rnd_val = 1'b1;
    start_test();
    for (int i = 0; i < 28; i++) send_px(i / W, i % W, (i == 0), 1'b0);
    idle(2);
    chk("t4_no_fd", n_fd == 0, n_fd, 0);
    start_test();
    send_frame(1'b0);
    idle(3);
    chk("t4_nwin", n_win == 9, n_win, 9);
    chk("t4_nfd", n_fd == 1, n_fd, 1);
    chk("t4_first_win", first_win_at == 46, first_win_at, 46);

    // 5: reset mid-frame, fresh frame without sof
    start_test();
    for (int i = 0; i < 30; i++) send_px(i / W, i % W, (i == 0), 1'b0);
    reset     = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'hff;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    last_acc  = 1'b0;
    chk_zero("t5_reset");
    reset = 1'b1;
    mrow  = 0;
    mcol  = 0;
    start_test();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_px(r, c, 1'b0, 1'b0);
    idle(3);
    chk("t5_nwin", n_win == 9, n_win, 9);
    chk("t5_nfd", n_fd == 1, n_fd, 1);
    chk("t5_first_win", first_win_at == 46, first_win_at, 46);
    chk("t5_fd_at", fd_at == 64, fd_at, 64);

    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    chk("queue_drained", q.size() == 0, q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
